node_position_streamer: RTL

- Downstream consumer of a simulation core's flattened node-position buses (`all_nodes_x_position`, `all_nodes_y_position`).
- On a frame tick, atomically snapshots every node's x/y field into shadow registers.
- Then streams the snapshot one node per handshake over a valid/ready interface toward the render/display path.
- Decouples the core's update rate from the consumer's drain rate and counts frames the consumer was too slow to take.

---
 rtl/node_position_streamer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/node_position_streamer.sv
// node_position_streamer
//
// Takes a snapshot of every node's x/y position from the simulation core's
// flattened buses when a frame tick arrives. It then streams that snapshot
// to the render path one node per valid/ready handshake.
//
// One extra frame tick can wait as a pending request while a frame is
// streaming. Any further ticks are dropped and counted in overrun_count.
//
// Ports:
//   clk                  system clock, all state updates on rising edge
//   reset                asynchronous, active-low reset
//   frame_tick           single-cycle request to snapshot and stream a frame
//   all_nodes_x_position node i x field at bits [(width-1)*i +: width-1]
//   all_nodes_y_position node i y field, same packing
//   out_valid            out_* fields hold a valid node
//   out_ready            consumer accepts on out_valid && out_ready
//   out_x / out_y        snapshot fields of node out_index, zero-extended
//   out_index            node number 0..node_contains-1
//   out_last             high with out_valid on the final node of a frame
//   busy                 high while streaming
//   frame_done           one-cycle pulse after the final node is accepted
//   overrun_count        saturating count of dropped frame ticks
module node_position_streamer #(
    parameter int node_contains = 5,
    parameter int width         = 32,
    parameter int idx_w         = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  frame_tick,
    input  logic [(width-1)*node_contains-1:0]    all_nodes_x_position,
    input  logic [(width-1)*node_contains-1:0]    all_nodes_y_position,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [width-1:0]                      out_x,
    output logic [width-1:0]                      out_y,
    output logic [idx_w-1:0]                      out_index,
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  frame_done,
    output logic [7:0]                            overrun_count
);

    localparam int               fw       = width - 1;
    localparam logic [idx_w-1:0] last_idx = idx_w'(node_contains - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state, state_next;
    logic [idx_w-1:0] index, index_next;
    logic             pending, pending_next;
    logic             frame_done_next;
    logic [7:0]       overrun_next;
    logic             capture;
    logic             handshake;
    logic             at_last;

    logic [fw-1:0]    shadow_x [node_contains];
    logic [fw-1:0]    shadow_y [node_contains];

    assign handshake = (state == SEND) && out_ready;
    assign at_last   = (index == last_idx);

    // State register. A reset abandons any frame in progress. No frame_done
    // is produced because the frame_done register is also cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode.
    // The final handshake of a frame has priority over ordinary tick
    // handling. At that edge, a held request or a tick arriving on the same
    // edge restarts the frame with no bubble on out_valid. If both a held
    // request and a new tick are present, the held one is used and the new
    // tick becomes the held request, so no overrun is counted.
    always_comb begin
        state_next      = state;
        index_next      = index;
        pending_next    = pending;
        overrun_next    = overrun_count;
        frame_done_next = 1'b0;
        capture         = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    capture    = 1'b1;
                    index_next = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (handshake && at_last) begin
                    frame_done_next = 1'b1;
                    index_next      = '0;
                    if (pending || frame_tick) begin
                        capture      = 1'b1;
                        pending_next = pending && frame_tick;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    if (handshake) begin
                        index_next = index + 1'b1;
                    end
                    if (frame_tick) begin
                        if (!pending) begin
                            pending_next = 1'b1;
                        end else if (overrun_count != 8'hFF) begin
                            overrun_next = overrun_count + 8'd1;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers: index, pending flag, overrun counter, the
    // frame_done pulse, and the shadow snapshot. The shadow registers load
    // only on capture edges. The streamed values therefore stay fixed for
    // the whole frame, even if the core keeps updating the buses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index         <= '0;
            pending       <= 1'b0;
            overrun_count <= '0;
            frame_done    <= 1'b0;
            for (int i = 0; i < node_contains; i++) begin
                shadow_x[i] <= '0;
                shadow_y[i] <= '0;
            end
        end else begin
            index         <= index_next;
            pending       <= pending_next;
            overrun_count <= overrun_next;
            frame_done    <= frame_done_next;
            if (capture) begin
                for (int i = 0; i < node_contains; i++) begin
                    shadow_x[i] <= all_nodes_x_position[fw*i +: fw];
                    shadow_y[i] <= all_nodes_y_position[fw*i +: fw];
                end
            end
        end
    end

    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_last  = (state == SEND) && at_last;
    assign out_index = index;
    assign out_x     = {1'b0, shadow_x[index]};
    assign out_y     = {1'b0, shadow_y[index]};

endmodule
